// File: rtl/cdb_arbiter.sv
// Completion-side CDB arbiter: per-FU result FIFOs feeding a single
// round-robin broadcast onto the common data bus.
module cdb_arbiter #(
    parameter int NUM_FU    = 5,
    parameter int PR_W      = 6,
    parameter int DATA_W    = 64,
    parameter int BUF_DEPTH = 2,
    parameter int ZERO_PR   = 31
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     rollback_en,
    input  logic [NUM_FU-1:0]        fu_done,
    input  logic [NUM_FU*PR_W-1:0]   fu_T_idx,
    input  logic [NUM_FU*DATA_W-1:0] fu_result,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     complete_en,
    output logic [PR_W-1:0]          CDB_T,
    output logic [DATA_W-1:0]        CDB_value
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam logic [PR_W-1:0]  ZERO_T = PR_W'(ZERO_PR);
    localparam logic [CNT_W-1:0] FULL   = CNT_W'(BUF_DEPTH);

    logic [CNT_W-1:0]  cnt_q  [NUM_FU];
    logic [CNT_W-1:0]  cnt_d  [NUM_FU];
    logic [PTR_W-1:0]  head_q [NUM_FU];
    logic [PTR_W-1:0]  head_d [NUM_FU];
    logic [PTR_W-1:0]  tail_q [NUM_FU];
    logic [PTR_W-1:0]  tail_d [NUM_FU];
    logic [PR_W-1:0]   tag_q  [NUM_FU][BUF_DEPTH];
    logic [PR_W-1:0]   tag_d  [NUM_FU][BUF_DEPTH];
    logic [DATA_W-1:0] data_q [NUM_FU][BUF_DEPTH];
    logic [DATA_W-1:0] data_d [NUM_FU][BUF_DEPTH];
    logic [RR_W-1:0]   rr_q;
    logic [RR_W-1:0]   rr_d;

    logic              grant_vld;
    logic [RR_W-1:0]   grant;
    logic [RR_W-1:0]   cand;
    logic [NUM_FU-1:0] push_v;
    logic [NUM_FU-1:0] pop_v;

    function automatic logic [RR_W-1:0] wrap_add(input logic [RR_W-1:0] a,
                                                 input int k);
        int s;
        s = int'(a) + k;
        if (s >= NUM_FU) s = s - NUM_FU;
        return RR_W'(s);
    endfunction

    // First non-empty FIFO at or after rr_q, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        cand      = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand = wrap_add(rr_q, k);
            if (!grant_vld && cnt_q[cand] != '0) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = cnt_q[i] < FULL;
        end
        complete_en = en && !rollback_en && grant_vld;
        CDB_T       = complete_en ? tag_q[grant][head_q[grant]] : ZERO_T;
        CDB_value   = complete_en ? data_q[grant][head_q[grant]] : '0;
    end

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        tag_d  = tag_q;
        data_d = data_q;
        rr_d   = rr_q;
        push_v = '0;
        pop_v  = '0;
        if (rollback_en) begin
            for (int i = 0; i < NUM_FU; i++) begin
                cnt_d[i]  = '0;
                head_d[i] = '0;
                tail_d[i] = '0;
            end
            rr_d = '0;
        end else if (en) begin
            for (int i = 0; i < NUM_FU; i++) begin
                // Results tagged ZERO_PR complete the handshake but carry nothing.
                push_v[i] = fu_done[i] && fu_ready[i]
                         && fu_T_idx[i*PR_W +: PR_W] != ZERO_T;
                pop_v[i]  = complete_en && grant == RR_W'(i);
                if (push_v[i]) begin
                    tag_d[i][tail_q[i]]  = fu_T_idx[i*PR_W +: PR_W];
                    data_d[i][tail_q[i]] = fu_result[i*DATA_W +: DATA_W];
                    tail_d[i] = tail_q[i] + PTR_W'(1);
                end
                if (pop_v[i]) begin
                    head_d[i] = head_q[i] + PTR_W'(1);
                end
                cnt_d[i] = cnt_q[i] + CNT_W'(push_v[i]) - CNT_W'(pop_v[i]);
            end
            if (complete_en) rr_d = wrap_add(grant, 1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                cnt_q[i]  <= '0;
                head_q[i] <= '0;
                tail_q[i] <= '0;
            end
            rr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            rr_q   <= rr_d;
        end
    end

    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-cycle vector table plus a broadcast
// scoreboard that checks every CDB tag/value pair in order.
module tb_cdb_arbiter;

    localparam int NF = 5;
    localparam int PW = 6;
    localparam int DW = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b1;
    logic              rollback_en = 1'b0;
    logic [NF-1:0]     fu_done = '0;
    logic [NF*PW-1:0]  fu_T_idx = '0;
    logic [NF*DW-1:0]  fu_result = '0;
    logic [NF-1:0]     fu_ready;
    logic              complete_en;
    logic [PW-1:0]     CDB_T;
    logic [DW-1:0]     CDB_value;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0]  done;
        logic [29:0] tags;
        logic        e;
        logic        rb;
        logic [4:0]  rdy;
        logic        ce;
        logic [5:0]  t;
    } vec_t;

    vec_t tbl[$];
    logic [PW+DW-1:0] sb[$];

    cdb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .rollback_en (rollback_en),
        .fu_done     (fu_done),
        .fu_T_idx    (fu_T_idx),
        .fu_result   (fu_result),
        .fu_ready    (fu_ready),
        .complete_en (complete_en),
        .CDB_T       (CDB_T),
        .CDB_value   (CDB_value)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] val_of(input logic [5:0] t);
        if (t == 6'd12) return 64'hABCD;
        return 64'hF00D_0000_0000_0000 | ({58'd0, t} << 24) | {58'd0, ~t};
    endfunction

    function automatic logic [29:0] pk(input int a, input int b, input int c,
                                       input int d, input int f);
        return {6'(f), 6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic add(input logic [4:0] d, input logic [29:0] tg,
                       input logic e, input logic rb, input logic [4:0] xr,
                       input logic xc, input logic [5:0] xt);
        vec_t v;
        v.done = d; v.tags = tg; v.e = e; v.rb = rb;
        v.rdy = xr; v.ce = xc; v.t = xt;
        tbl.push_back(v);
    endtask

    task automatic cyc(input logic [4:0] d, input logic [29:0] tg,
                       input logic e, input logic rb, input logic [4:0] xr,
                       input logic xc, input logic [5:0] xt, input string nm);
        fu_done = d;
        fu_T_idx = tg;
        en = e;
        rollback_en = rb;
        for (int i = 0; i < NF; i++) begin
            fu_result[i*DW +: DW] = val_of(tg[i*PW +: PW]);
        end
        if (xc) sb.push_back({xt, val_of(xt)});
        @(negedge clock);
        n_chk++;
        if (fu_ready !== xr) begin
            n_fail++;
            $display("FAIL %s fu_ready got %b want %b", nm, fu_ready, xr);
        end
        n_chk++;
        if (complete_en !== xc) begin
            n_fail++;
            $display("FAIL %s complete_en got %b want %b", nm, complete_en, xc);
        end
        n_chk++;
        if (CDB_T !== xt) begin
            n_fail++;
            $display("FAIL %s CDB_T got %0d want %0d", nm, CDB_T, xt);
        end
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every broadcast must match the next expected entry;
    // an idle bus must show the reserved tag and zero data.
    always @(negedge clock) begin
        if (!reset) begin
            n_chk++;
            if (complete_en === 1'b1) begin
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected got T=%0d val=%h want none",
                             CDB_T, CDB_value);
                end else begin
                    logic [PW+DW-1:0] x;
                    x = sb.pop_front();
                    if ({CDB_T, CDB_value} !== x) begin
                        n_fail++;
                        $display("FAIL sb_data got T=%0d val=%h want T=%0d val=%h",
                                 CDB_T, CDB_value, x[DW +: PW], x[DW-1:0]);
                    end
                end
            end else if (CDB_T !== 6'd31 || CDB_value !== 64'd0) begin
                n_fail++;
                $display("FAIL sb_idle got T=%0d val=%h want T=31 val=0",
                         CDB_T, CDB_value);
            end
        end
    end

    initial begin
        // Reset state and idle bus
        repeat (3) add(5'h00, 30'd0, 1, 0, 5'h1F, 0, 6'd31);
        // Single result, one-cycle latency
        add(5'b00100, pk(0, 0, 12, 0, 0), 1, 0, 5'h1F, 0, 6'd31);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd12);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 0, 6'd31);
        // All five with rr_ptr at 3
        add(5'h1F, pk(1, 2, 3, 4, 5), 1, 0, 5'h1F, 0, 6'd31);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd4);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd5);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd1);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd2);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd3);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 0, 6'd31);
        // FU4 alone moves rr_ptr back to 0
        add(5'b10000, pk(0, 0, 0, 0, 20), 1, 0, 5'h1F, 0, 6'd31);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd20);
        // All five with rr_ptr at 0
        add(5'h1F, pk(1, 2, 3, 4, 5), 1, 0, 5'h1F, 0, 6'd31);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd1);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd2);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd3);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd4);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd5);
        add(5'h00, 30'd0, 1, 0, 5'h1F, 0, 6'd31);

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            cyc(tbl[k].done, tbl[k].tags, tbl[k].e, tbl[k].rb,
                tbl[k].rdy, tbl[k].ce, tbl[k].t, $sformatf("vec%0d", k));
        end

        // FU1 back-to-back against a continuously refilled FU0
        cyc(5'b00011, pk(40, 1, 0, 0, 0), 1, 0, 5'h1F, 0, 6'd31, "bp0");
        cyc(5'b00011, pk(41, 2, 0, 0, 0), 1, 0, 5'h1F, 1, 6'd40, "bp1");
        cyc(5'b00011, pk(42, 3, 0, 0, 0), 1, 0, 5'b11101, 1, 6'd1, "bp2");
        cyc(5'b00011, pk(43, 3, 0, 0, 0), 1, 0, 5'b11110, 1, 6'd41, "bp3");
        cyc(5'b00001, pk(43, 0, 0, 0, 0), 1, 0, 5'b11101, 1, 6'd2, "bp4");
        cyc(5'h00, 30'd0, 1, 0, 5'b11110, 1, 6'd42, "bp5");
        cyc(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd3, "bp6");
        cyc(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd43, "bp7");
        cyc(5'h00, 30'd0, 1, 0, 5'h1F, 0, 6'd31, "bp8");

        // Stall with en low; a done during the stall is dropped
        cyc(5'b01100, pk(0, 0, 7, 8, 0), 1, 0, 5'h1F, 0, 6'd31, "en0");
        cyc(5'b10000, pk(0, 0, 0, 0, 30), 0, 0, 5'h1F, 0, 6'd31, "en1");
        cyc(5'h00, 30'd0, 0, 0, 5'h1F, 0, 6'd31, "en2");
        cyc(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd7, "en3");
        cyc(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd8, "en4");
        cyc(5'h00, 30'd0, 1, 0, 5'h1F, 0, 6'd31, "en5");

        // Rollback with three entries held and FU1 full
        cyc(5'b00011, pk(10, 11, 0, 0, 0), 1, 0, 5'h1F, 0, 6'd31, "rb0");
        cyc(5'b00110, pk(0, 15, 13, 0, 0), 1, 0, 5'h1F, 1, 6'd10, "rb1");
        cyc(5'b00001, pk(9, 0, 0, 0, 0), 1, 1, 5'b11101, 0, 6'd31, "rb2");
        cyc(5'h00, 30'd0, 1, 0, 5'h1F, 0, 6'd31, "rb3");
        cyc(5'h00, 30'd0, 1, 0, 5'h1F, 0, 6'd31, "rb4");

        // Reserved tag is accepted but never stored or broadcast
        cyc(5'b01000, pk(0, 0, 0, 31, 0), 1, 0, 5'h1F, 0, 6'd31, "zp0");
        cyc(5'b01000, pk(0, 0, 0, 31, 0), 1, 0, 5'h1F, 0, 6'd31, "zp1");
        cyc(5'b01000, pk(0, 0, 0, 21, 0), 1, 0, 5'h1F, 0, 6'd31, "zp2");
        cyc(5'h00, 30'd0, 1, 0, 5'h1F, 1, 6'd21, "zp3");
        cyc(5'h00, 30'd0, 1, 0, 5'h1F, 0, 6'd31, "zp4");

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Completion-side counterpart of the reservation station.
- Collects finished results from the functional units, buffers them per FU, and picks one per cycle round-robin.
- Drives the common data bus (CDB_T, CDB_value, complete_en), which the RS, map table and ROB snoop to wake up operands and mark completion.
- Back-pressures the FUs when their buffer is full.

Parameters:
- NUM_FU, 5, number of functional units; index order matches FU_LIST.
- PR_W, 6, physical register tag width.
- DATA_W, 64, result width.
- BUF_DEPTH, 2, per-FU result FIFO depth; power of two, ≥2.
- ZERO_PR, 31, reserved always-ready tag; driven on CDB_T when the bus is idle.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- en  in  1  pipeline advance enable; state updates only when high
- rollback_en  in  1  branch-mispredict flush of all buffered results
- fu_done  in  NUM_FU  per-FU result valid
- fu_T_idx  in  NUM_FU*PR_W  per-FU destination tag
- fu_result  in  NUM_FU*DATA_W  per-FU result value
- fu_ready  out  NUM_FU  per-FU buffer can accept this cycle
- complete_en  out  1  CDB valid
- CDB_T  out  PR_W  broadcast tag
- CDB_value  out  DATA_W  broadcast value

Behaviour:
- Reset (synchronous, clock edge with reset=1):
  - All FIFO counts and pointers are 0 and rr_ptr is 0.
  - Outputs: complete_en=0, CDB_T=ZERO_PR, CDB_value=0, fu_ready=all ones.
  - Reset overrides en and rollback_en.
- Per-FU FIFO:
  - fu_ready[i] = (count[i] < BUF_DEPTH), computed from registered count only; it does not look ahead to this cycle's pop.
  - Push when en && !rollback_en && fu_done[i] && fu_ready[i]. Stores {T_idx, result}.
  - fu_done[i] with fu_T_idx[i]==ZERO_PR is accepted (handshake completes) but not stored.
  - fu_done[i] while fu_ready[i]=0 is ignored; the FU must hold its result and retry.
- Arbitration, combinational from registered state:
  - Candidates are FIFOs with count>0.
  - Grant the first candidate at or after rr_ptr, wrapping NUM_FU-1→0.
  - If en && !rollback_en && a grant exists: complete_en=1, CDB_T and CDB_value come from the granted FIFO head.
  - Otherwise: complete_en=0, CDB_T=ZERO_PR, CDB_value=0.
  - CDB_T must never carry a live tag while complete_en=0, because snoopers compare tags without qualifying on complete_en.
- Pop and pointer update:
  - When complete_en=1, pop the granted head at the clock edge and set rr_ptr <= (grant+1) mod NUM_FU.
  - rr_ptr is unchanged when there is no grant.
- Latency: a result pushed at edge N is broadcast at the earliest in the cycle after edge N. There is no same-cycle bypass.
- Simultaneous push and pop on the same FIFO: count is unchanged and FIFO order is preserved. A full FIFO cannot push in the cycle it pops, because fu_ready is based on the pre-pop count.
- Throughput: at most one broadcast per cycle. Each FU is guaranteed a grant within NUM_FU cycles while its FIFO is non-empty.
- en=0: no push, no pop, rr_ptr held, bus idle (complete_en=0, CDB_T=ZERO_PR).
- rollback_en=1 (en ignored):
  - Bus idle that cycle and incoming fu_done dropped.
  - At the edge, all counts/pointers clear and rr_ptr returns to 0.
  - fu_ready reads all ones in the following cycle.
- Pointer arithmetic:
  - FIFO head/tail pointers are log2(BUF_DEPTH) bits and wrap naturally.
  - count is log2(BUF_DEPTH)+1 bits.

Test Plan:
- Reset then idle 3 cycles → complete_en=0, CDB_T=31, CDB_value=0, fu_ready=5'b11111.
- Cycle 0: fu_done=5'b00100, T_idx=12, result=0xABCD → cycle 1: complete_en=1, CDB_T=12, CDB_value=0xABCD. Cycle 2 idle.
- Cycle 0: all 5 FUs done with tags 1..5, rr_ptr=0 → cycles 1–5 broadcast tags 1,2,3,4,5 in order. Repeat with rr_ptr=3 → order 4,5,1,2,3.
- FU1 done 3 consecutive cycles while FU0 is continuously refilled (tags 1,2,3 on FU1) →
  - fu_ready[1]=0 once 2 entries are held.
  - FU1 tags broadcast in order 1,2,3 with no loss.
  - Alternates with FU0 per round-robin.
- Two entries buffered, then en=0 for 2 cycles → complete_en=0 and CDB_T=31 throughout, nothing popped. en=1 → both broadcast on the next 2 cycles.
- Three entries buffered, then rollback_en=1 with fu_done[0]=1 (tag 9) the same cycle → bus idle, tag 9 never broadcast, fu_ready=all ones next cycle. fu_done with T_idx=31 → fu_ready handshake completes, never broadcast.
